// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues one instruction-memory request at a time
// and buffers returned words in a 2-entry FIFO feeding decode.
module if_fetch_queue (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        ce_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        flush_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNTW  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DISCARD = 2'd2
   } state_e;

   state_e            state_q;
   logic [XLEN-1:0]   pending_pc_q;
   logic [XLEN-1:0]   pc_q   [DEPTH];
   logic [XLEN-1:0]   inst_q [DEPTH];
   logic              head_q;
   logic [CNTW-1:0]   count_q;
   logic [CNTW-1:0]   count_d;

   logic              grant;
   logic              push;
   logic              pop;
   logic              tail;

   // A request may only leave when nothing is outstanding and a slot is free.
   assign mem_req_o  = !rst && ce_i && !flush_i && (state_q == IDLE)
                       && (count_q < CNTW'(DEPTH));
   assign mem_addr_o = pc_i;
   assign grant      = mem_req_o && mem_gnt_i;
   assign stall_o    = ce_i && !grant;

   assign id_valid_o = !rst && (count_q != '0);
   assign id_pc_o    = id_valid_o ? pc_q[head_q]   : '0;
   assign id_inst_o  = id_valid_o ? inst_q[head_q] : '0;

   assign pop  = id_valid_o && id_ready_i;
   assign push = (state_q == BUSY) && mem_rvalid_i && !flush_i;
   // Slot behind the last valid entry; with count=2 this is the head being popped.
   assign tail = head_q ^ count_q[0];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pending_pc_q <= '0;
         head_q       <= 1'b0;
         count_q      <= '0;
      end else begin
         if (push) begin
            pc_q[tail]   <= pending_pc_q;
            inst_q[tail] <= mem_rdata_i;
         end

         if (flush_i) begin
            head_q  <= 1'b0;
            count_q <= '0;
         end else begin
            if (pop) head_q <= ~head_q;
            count_q <= count_d;
         end

         unique case (state_q)
            IDLE: begin
               if (grant) begin
                  pending_pc_q <= pc_i;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               if (mem_rvalid_i)  state_q <= IDLE;
               else if (flush_i)  state_q <= DISCARD;
            end
            DISCARD: begin
               if (mem_rvalid_i)  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i = '0;
   logic        ce_i = 1'b0;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        flush_i = 1'b0;
   logic        id_valid_o;
   logic        id_ready_i = 1'b0;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   int total = 0;
   int bad   = 0;
   bit run   = 1'b0;

   // Reference model: a queue of fetched {pc, inst} plus the single in-flight fetch.
   logic [63:0] mq[$];
   bit          m_out    = 1'b0;
   bit          m_doomed = 1'b0;
   logic [31:0] m_ppc    = '0;
   bit          m_granted = 1'b0;

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .ce_i         (ce_i),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .flush_i      (flush_i),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .id_pc_o      (id_pc_o),
      .id_inst_o    (id_inst_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_req();
      return !rst && ce_i && !flush_i && !m_out && (mq.size() < 2);
   endfunction

   // Compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      if (run) begin
         logic ev;
         ev = !rst && (mq.size() != 0);
         chk("mem_req",  32'(mem_req_o),  32'(exp_req()));
         chk("stall",    32'(stall_o),    32'(ce_i && !(exp_req() && mem_gnt_i)));
         chk("mem_addr", mem_addr_o,      pc_i);
         chk("id_valid", 32'(id_valid_o), 32'(ev));
         chk("id_pc",    id_pc_o,   ev ? mq[0][63:32] : 32'h0);
         chk("id_inst",  id_inst_o, ev ? mq[0][31:0]  : 32'h0);
      end
   end

   // Model update at each edge from the inputs held across it.
   always @(posedge clk) begin
      bit g, popv;
      g    = exp_req() && mem_gnt_i;
      popv = !rst && (mq.size() != 0) && id_ready_i;
      m_granted = g;
      if (rst) begin
         mq.delete();
         m_out = 1'b0; m_doomed = 1'b0; m_ppc = '0;
      end else begin
         if (flush_i) mq.delete();
         else begin
            if (popv) void'(mq.pop_front());
            if (m_out && !m_doomed && mem_rvalid_i) mq.push_back({m_ppc, mem_rdata_i});
         end
         if (m_out) begin
            if (mem_rvalid_i) begin m_out = 1'b0; m_doomed = 1'b0; end
            else if (flush_i) m_doomed = 1'b1;
         end else if (g) begin
            m_out = 1'b1; m_doomed = 1'b0; m_ppc = pc_i;
         end
      end
   end

   task automatic cyc(input bit r, input bit ce, input logic [31:0] pc, input bit gnt,
                      input bit rv, input logic [31:0] rd, input bit fl, input bit rdy);
      @(posedge clk); #1;
      rst = r; ce_i = ce; pc_i = pc; mem_gnt_i = gnt;
      mem_rvalid_i = rv; mem_rdata_i = rd; flush_i = fl; id_ready_i = rdy;
      run = 1'b1;
      @(negedge clk); #1;
   endtask

   initial begin
      logic [31:0] pc;
      // Basic fetch: 1-cycle rvalid-to-id_valid latency
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_valid", 32'(id_valid_o), 32'h0);
      chk("rst_req",   32'(mem_req_o),  32'h0);
      cyc(1, 1, 0, 1, 1, 32'hDEAD, 0, 1);
      chk("rst_stall", 32'(stall_o), 32'h1);
      cyc(0, 1, 32'h0, 1, 0, 0, 0, 1);
      chk("b_stall", 32'(stall_o),   32'h0);
      chk("b_req",   32'(mem_req_o), 32'h1);
      cyc(0, 0, 32'h4, 0, 1, 32'h3401FFFF, 0, 1);
      chk("b_lat",   32'(id_valid_o), 32'h0);
      cyc(0, 0, 32'h4, 0, 0, 0, 0, 1);
      chk("b_valid", 32'(id_valid_o), 32'h1);
      chk("b_pc",    id_pc_o,   32'h0);
      chk("b_inst",  id_inst_o, 32'h3401FFFF);

      // Saturation at two entries
      cyc(0, 1, 32'h0, 1, 0, 0, 0, 0);
      cyc(0, 0, 32'h4, 0, 1, 32'hA0, 0, 0);
      cyc(0, 1, 32'h4, 1, 0, 0, 0, 0);
      cyc(0, 0, 32'h8, 0, 1, 32'hA4, 0, 0);
      cyc(0, 1, 32'h8, 1, 0, 0, 0, 0);
      chk("s_req",   32'(mem_req_o), 32'h0);
      chk("s_stall", 32'(stall_o),   32'h1);
      cyc(0, 1, 32'h8, 1, 0, 0, 0, 1);
      chk("s_pop0",  id_pc_o, 32'h0);
      cyc(0, 1, 32'h8, 1, 0, 0, 0, 0);
      chk("s_req8",  32'(mem_req_o), 32'h1);
      chk("s_head4", id_pc_o, 32'h4);
      cyc(0, 0, 32'hC, 0, 1, 32'hA8, 0, 1);
      chk("s_pop4",  id_pc_o, 32'h4);
      cyc(0, 0, 32'hC, 0, 0, 0, 0, 1);
      chk("s_pop8",  id_pc_o,   32'h8);
      chk("s_inst8", id_inst_o, 32'hA8);

      // Grant withheld for three cycles
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 32'h10, 0, 0, 0, 0, 0);
         chk("g_req",   32'(mem_req_o), 32'h1);
         chk("g_stall", 32'(stall_o),   32'h1);
      end
      cyc(0, 1, 32'h10, 1, 0, 0, 0, 0);
      cyc(0, 0, 32'h14, 0, 1, 32'hB0, 0, 0);
      cyc(0, 0, 32'h14, 0, 0, 0, 0, 1);
      chk("g_pc", id_pc_o, 32'h10);
      cyc(0, 0, 32'h14, 0, 0, 0, 0, 1);
      chk("g_single", 32'(id_valid_o), 32'h0);

      // Flush while busy: response dropped, next request waits for the drop
      cyc(0, 1, 32'h20, 1, 0, 0, 0, 0);
      cyc(0, 1, 32'h24, 1, 0, 0, 1, 0);
      cyc(0, 1, 32'h24, 1, 0, 0, 0, 0);
      chk("f_disc_req", 32'(mem_req_o), 32'h0);
      cyc(0, 1, 32'h24, 1, 1, 32'hC0, 0, 0);
      chk("f_drop_req", 32'(mem_req_o), 32'h0);
      cyc(0, 1, 32'h24, 0, 0, 0, 0, 0);
      chk("f_novalid",  32'(id_valid_o), 32'h0);
      chk("f_req",      32'(mem_req_o),  32'h1);

      // Flush with full queue and simultaneous push/pop
      cyc(0, 1, 32'h40, 1, 0, 0, 0, 0);
      cyc(0, 0, 32'h44, 0, 1, 32'hD0, 0, 0);
      cyc(0, 1, 32'h44, 1, 0, 0, 0, 0);
      cyc(0, 0, 32'h48, 0, 1, 32'hD4, 0, 0);
      cyc(0, 0, 32'h48, 0, 0, 0, 0, 1);
      cyc(0, 1, 32'h48, 1, 0, 0, 0, 0);
      cyc(0, 0, 32'h60, 0, 1, 32'hD8, 1, 1);
      cyc(0, 0, 32'h60, 0, 0, 0, 0, 0);
      chk("fl_valid", 32'(id_valid_o), 32'h0);
      chk("fl_pc",    id_pc_o, 32'h0);

      // Reset while busy with a same-cycle response
      cyc(0, 1, 32'h50, 1, 0, 0, 0, 0);
      cyc(1, 0, 32'h54, 0, 1, 32'hE0, 0, 0);
      chk("r_req",   32'(mem_req_o),  32'h0);
      cyc(0, 0, 32'h54, 0, 1, 32'hE4, 0, 0);
      chk("r_valid", 32'(id_valid_o), 32'h0);
      chk("r_inst",  id_inst_o, 32'h0);
      cyc(0, 0, 32'h54, 0, 0, 0, 0, 0);
      chk("r_idle_rv", 32'(id_valid_o), 32'h0);

      // Randomized traffic; PC advances only after a grant, redirects on flush
      pc = 32'h1000;
      for (int n = 0; n < 4000; n++) begin
         bit r, fl;
         r  = ($urandom_range(0, 199) == 0);
         fl = ($urandom_range(0, 19) == 0);
         if (m_granted) pc = pc + 32'd4;
         if (fl) pc = {$urandom_range(0, 32'hFFFF), 2'b00};
         cyc(r, ($urandom_range(0, 9) != 0), pc, ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 9) < 4), $urandom, fl, ($urandom_range(0, 9) < 5));
         if (mq.size() > 2) chk("model_depth", 32'(mq.size()), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
